// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU sequencer: opcode values,
// instruction field layout, FSM state encoding and the DEC/N2 dispatch rule.
package cpu_pkg;

  // ALU / transfer opcodes as they appear in IR[DATA_W-2:DATA_W-4]
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_SHL = 3'b011;
  localparam logic [2:0] OP_LDA = 3'b100;
  localparam logic [2:0] OP_STA = 3'b101;
  localparam logic [2:0] OP_CMA = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  // Instruction layout {I, opcode[2:0], addr}: positions counted down from the MSB
  localparam int IND_FROM_TOP = 1;
  localparam int OPC_FROM_TOP = 2;
  localparam int OPC_W        = 3;

  // One state per machine cycle
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_F0    = 4'd1,
    ST_F1    = 4'd2,
    ST_F2    = 4'd3,
    ST_DEC   = 4'd4,
    ST_N1    = 4'd5,
    ST_N2    = 4'd6,
    ST_OP1   = 4'd7,
    ST_EXEC  = 4'd8,
    ST_STORE = 4'd9,
    ST_HALT  = 4'd10
  } cpu_state_e;

  // Instruction class flags produced by the decoder
  typedef struct packed {
    logic is_memref;
    logic is_alu;
    logic is_store;
    logic is_halt;
  } instr_class_t;

  // Successor of DEC (ind = I bit) and of N2 (ind forced low: single-level indirection)
  function automatic cpu_state_e dispatch(input instr_class_t cls, input logic ind);
    cpu_state_e nxt;
    if (cls.is_halt) begin
      nxt = ST_HALT;
    end else if (!cls.is_memref) begin
      nxt = ST_EXEC;
    end else if (ind) begin
      nxt = ST_N1;
    end else if (cls.is_store) begin
      nxt = ST_STORE;
    end else begin
      nxt = ST_OP1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/cpu_control_unit_chk.sv
// Protocol assertions on the sequencer's memory and ALU strobes.
module cpu_control_unit_chk
  import cpu_pkg::*;
(
  input logic       CLK,
  input logic       RST,
  input logic       mem_we,
  input logic       alu_enable,
  input logic [2:0] alu_opcode,
  input logic       busy,
  input logic       halted
);

  // A store strobe never lasts more than one cycle
  a_we_single: assert property (@(posedge CLK) disable iff (RST) mem_we |=> !mem_we);

  // Memory write and ALU enable belong to different states
  a_we_alu_excl: assert property (@(posedge CLK) disable iff (RST) !(mem_we && alu_enable));

  // HALT is not a busy state
  a_halt_not_busy: assert property (@(posedge CLK) disable iff (RST) halted |-> !busy);

  // Only the five ALU opcodes ever get an enable
  a_alu_legal: assert property (@(posedge CLK) disable iff (RST)
    alu_enable |-> (alu_opcode == OP_ADD || alu_opcode == OP_SUB || alu_opcode == OP_XOR ||
                    alu_opcode == OP_SHL || alu_opcode == OP_CMA));

endmodule

// File: rtl/cpu_instr_decode.sv
// Combinational opcode classifier used by the sequencer's DEC and N2 dispatch.
module cpu_instr_decode
  import cpu_pkg::*;
(
  input  logic [2:0]   opcode,
  output instr_class_t cls
);

  // Map each opcode to its class flags; unknown codes fall back to a harmless halt
  always_comb begin
    cls = '{is_memref: 1'b0, is_alu: 1'b0, is_store: 1'b0, is_halt: 1'b0};
    case (opcode)
      OP_ADD, OP_SUB, OP_XOR: begin
        cls.is_memref = 1'b1;
        cls.is_alu    = 1'b1;
      end
      OP_SHL, OP_CMA: begin
        cls.is_alu    = 1'b1;
      end
      OP_LDA: begin
        cls.is_memref = 1'b1;
      end
      OP_STA: begin
        cls.is_memref = 1'b1;
        cls.is_store  = 1'b1;
      end
      OP_HLT: begin
        cls.is_halt   = 1'b1;
      end
      default: begin
        cls.is_halt   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle sequencer of the 8-bit accumulator CPU. Owns PC, AR, IR and AC,
// fetches through the synchronous memory, handles one level of indirection and
// drives the external ALU, writing its result back into AC.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 4,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        alu_opcode,
  output logic              alu_enable,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] ac_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] ir_out,
  output logic              busy,
  output logic              halted
);

  localparam int IND_BIT = DATA_W - IND_FROM_TOP;
  localparam int OPC_HI  = DATA_W - OPC_FROM_TOP;
  localparam int OPC_LO  = OPC_HI - OPC_W + 1;

  // Architectural registers and their next values
  cpu_state_e        state_r, state_s;
  logic [ADDR_W-1:0] pc_r, pc_s;
  logic [ADDR_W-1:0] ar_r, ar_s;
  logic [DATA_W-1:0] ir_r, ir_s;
  logic [DATA_W-1:0] ac_r, ac_s;

  // Registered strobes, derived from the state being entered
  logic mem_we_r;
  logic alu_en_r;
  logic busy_r;
  logic halted_r;

  // Instruction fields and class of the instruction held in IR
  logic         ind_s;
  logic [2:0]   opc_s;
  instr_class_t cls_s;

  assign ind_s = ir_r[IND_BIT];
  assign opc_s = ir_r[OPC_HI:OPC_LO];

  cpu_instr_decode u_decode (
    .opcode (opc_s),
    .cls    (cls_s)
  );

  // Next-state and register-update logic, one FSM state per cycle
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    ar_s    = ar_r;
    ir_s    = ir_r;
    ac_s    = ac_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_F0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_F0: begin
        ar_s    = pc_r;
        state_s = ST_F1;
      end
      ST_F1: begin
        // memory samples AR at the end of this cycle
        state_s = ST_F2;
      end
      ST_F2: begin
        ir_s    = mem_rdata;
        pc_s    = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        state_s = ST_DEC;
      end
      ST_DEC: begin
        ar_s    = ir_r[ADDR_W-1:0];
        state_s = dispatch(cls_s, ind_s);
      end
      ST_N1: begin
        // memory samples the pointer location
        state_s = ST_N2;
      end
      ST_N2: begin
        ar_s    = mem_rdata[ADDR_W-1:0];
        state_s = dispatch(cls_s, 1'b0);
      end
      ST_OP1: begin
        // memory samples the operand location
        state_s = ST_EXEC;
      end
      ST_EXEC: begin
        if (cls_s.is_alu) begin
          ac_s = alu_result;
        end else begin
          ac_s = mem_rdata;
        end
        state_s = ST_F0;
      end
      ST_STORE: begin
        // memory captures AC at AR while mem_we is high
        state_s = ST_F0;
      end
      ST_HALT: begin
        if (start) begin
          state_s = ST_F0;
        end else begin
          state_s = ST_HALT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and architectural register update with asynchronous reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
      pc_r    <= RESET_PC;
      ar_r    <= {ADDR_W{1'b0}};
      ir_r    <= {DATA_W{1'b0}};
      ac_r    <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      ar_r    <= ar_s;
      ir_r    <= ir_s;
      ac_r    <= ac_s;
    end
  end

  // Output strobes registered from the state being entered so they are glitch-free
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem_we_r <= 1'b0;
      alu_en_r <= 1'b0;
      busy_r   <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      mem_we_r <= (state_s == ST_STORE);
      alu_en_r <= (state_s == ST_EXEC) && cls_s.is_alu;
      busy_r   <= (state_s != ST_IDLE) && (state_s != ST_HALT);
      halted_r <= (state_s == ST_HALT);
    end
  end

  assign mem_addr   = ar_r;
  assign mem_wdata  = ac_r;
  assign mem_we     = mem_we_r;
  assign alu_opcode = opc_s;
  assign alu_enable = alu_en_r;
  assign ac_out     = ac_r;
  assign pc_out     = pc_r;
  assign ir_out     = ir_r;
  assign busy       = busy_r;
  assign halted     = halted_r;

  cpu_control_unit_chk u_chk (
    .CLK        (CLK),
    .RST        (RST),
    .mem_we     (mem_we_r),
    .alu_enable (alu_en_r),
    .alu_opcode (opc_s),
    .busy       (busy_r),
    .halted     (halted_r)
  );

endmodule

// File: tb/tb_cpu_control_unit.sv
// Scoreboard bench for cpu_control_unit with a behavioural 16x8 memory and ALU.
module tb_cpu_control_unit;

  localparam logic [1:0] K_STORE = 2'd0;
  localparam logic [1:0] K_ALUEN = 2'd1;
  localparam logic [1:0] K_AC    = 2'd2;
  localparam logic [1:0] K_HALT  = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] exp;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       start = 1'b0;
  logic [3:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic [2:0] alu_opcode;
  logic       alu_enable;
  logic [7:0] alu_result;
  logic [7:0] ac_out;
  logic [3:0] pc_out;
  logic [7:0] ir_out;
  logic       busy;
  logic       halted;

  logic [7:0] mem [16];
  logic       ld_en = 1'b0;
  logic [3:0] ld_addr = 4'h0;
  logic [7:0] ld_data = 8'h00;

  exp_t sb_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  logic [7:0] prev_ac = 8'h00;
  logic       prev_halted = 1'b0;

  cpu_control_unit dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .alu_opcode (alu_opcode),
    .alu_enable (alu_enable),
    .alu_result (alu_result),
    .ac_out     (ac_out),
    .pc_out     (pc_out),
    .ir_out     (ir_out),
    .busy       (busy),
    .halted     (halted)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Synchronous memory: write on mem_we (or bench load), read data one cycle later
  always @(posedge CLK) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (ld_en) mem[ld_addr] <= ld_data;
    mem_rdata <= mem[mem_addr];
  end

  // Reference ALU
  always_comb begin
    case (alu_opcode)
      3'b000:  alu_result = ac_out + mem_rdata;
      3'b001:  alu_result = ac_out - mem_rdata;
      3'b010:  alu_result = ac_out ^ mem_rdata;
      3'b011:  alu_result = ac_out + ac_out;
      3'b110:  alu_result = ~ac_out;
      default: alu_result = 8'h00;
    endcase
  end

  function automatic string kname(input logic [1:0] k);
    case (k)
      K_STORE: return "store";
      K_ALUEN: return "alu_enable";
      K_AC:    return "ac_update";
      default: return "halt";
    endcase
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic sb_pop(input logic [1:0] kind, input logic [31:0] act);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      $display("FAIL unexpected_%s: got %h expected no event", kname(kind), act);
    end else begin
      e = sb_q.pop_front();
      check(kname(e.kind), {6'h0, kind, act}, {6'h0, e.kind, e.exp});
    end
  endtask

  function automatic void exp_store(input logic [3:0] a, input logic [7:0] d);
    sb_q.push_back('{kind: K_STORE, exp: {20'h0, a, d}});
  endfunction
  function automatic void exp_alu(input logic [2:0] op);
    sb_q.push_back('{kind: K_ALUEN, exp: {29'h0, op}});
  endfunction
  function automatic void exp_ac(input logic [3:0] a, input logic [7:0] d);
    sb_q.push_back('{kind: K_AC, exp: {20'h0, a, d}});
  endfunction
  function automatic void exp_halt(input logic [15:0] n, input logic [3:0] pc, input logic [7:0] ac);
    sb_q.push_back('{kind: K_HALT, exp: {4'h0, n, pc, ac}});
  endfunction

  // Monitor: turn DUT output events into scoreboard comparisons
  always @(negedge CLK) begin
    if (!RST) begin
      if (mem_we) sb_pop(K_STORE, {20'h0, mem_addr, mem_wdata});
      if (alu_enable) sb_pop(K_ALUEN, {29'h0, alu_opcode});
      if (ac_out !== prev_ac) sb_pop(K_AC, {20'h0, mem_addr, ac_out});
      if (halted && !prev_halted) sb_pop(K_HALT, {4'h0, 16'(cyc - start_cyc - 1), pc_out, ac_out});
    end
    prev_ac     <= ac_out;
    prev_halted <= halted;
  end

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    @(negedge CLK);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge CLK);
    ld_en = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_halt(input string name);
    int n = 0;
    while (halted !== 1'b1 && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (halted !== 1'b1) begin
      checks++;
      $display("FAIL %s_timeout: got halted=0 expected halted=1 within 300 cycles", name);
    end
    @(negedge CLK);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   {39'h0, busy},       40'h0);
    check({tag, "_halted"}, {39'h0, halted},     40'h0);
    check({tag, "_we"},     {39'h0, mem_we},     40'h0);
    check({tag, "_alu_en"}, {39'h0, alu_enable}, 40'h0);
    check({tag, "_ac"},     {32'h0, ac_out},     40'h0);
    check({tag, "_pc"},     {36'h0, pc_out},     40'h0);
    check({tag, "_ir"},     {32'h0, ir_out},     40'h0);
    check({tag, "_addr"},   {36'h0, mem_addr},   40'h0);
    check({tag, "_opcode"}, {37'h0, alu_opcode}, 40'h0);
  endtask

  initial begin
    #2;
    check_reset_outputs("por");
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // LDA 5; ADD 6; HLT
    load(4'd0, 8'h45); load(4'd1, 8'h06); load(4'd2, 8'h70);
    load(4'd5, 8'h10); load(4'd6, 8'h22);
    exp_ac(4'd5, 8'h10); exp_alu(3'b000); exp_ac(4'd6, 8'h32); exp_halt(16'd16, 4'd3, 8'h32);
    pulse_start();
    wait_halt("prog_add");

    // Resume from HALT and reset asynchronously while in F2
    pulse_start();
    @(posedge CLK);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1 check_reset_outputs("mid_f2");
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // LDA @8 -> M[9]; fetched from M[0] after reset
    load(4'd0, 8'hC8); load(4'd1, 8'h70); load(4'd8, 8'h09); load(4'd9, 8'hA5);
    exp_ac(4'd9, 8'hA5); exp_halt(16'd12, 4'd2, 8'hA5);
    pulse_start();
    wait_halt("prog_ind");

    // LDA 10; STA 12; LDA 11; SUB 13 (0x01 - 0x02 wraps); HLT
    load(4'd2, 8'h4A); load(4'd3, 8'h5C); load(4'd4, 8'h4B); load(4'd5, 8'h1D);
    load(4'd6, 8'h70); load(4'd10, 8'h5A); load(4'd11, 8'h01); load(4'd13, 8'h02);
    exp_ac(4'd10, 8'h5A); exp_store(4'hC, 8'h5A); exp_ac(4'd11, 8'h01);
    exp_alu(3'b001); exp_ac(4'd13, 8'hFF); exp_halt(16'd27, 4'd7, 8'hFF);
    pulse_start();
    wait_halt("prog_sta_sub");
    check("sta_mem12", {32'h0, mem[12]}, {32'h0, 8'h5A});

    // LDA 14; SHL with I=1 (ignored); LDA 15; CMA; HLT
    load(4'd7, 8'h4E); load(4'd8, 8'hB0); load(4'd9, 8'h4F); load(4'd10, 8'h60);
    load(4'd11, 8'h70); load(4'd14, 8'h81); load(4'd15, 8'h0F);
    exp_ac(4'd14, 8'h81); exp_alu(3'b011); exp_ac(4'd0, 8'h02);
    exp_ac(4'd15, 8'h0F); exp_alu(3'b110); exp_ac(4'd0, 8'hF0); exp_halt(16'd26, 4'd12, 8'hF0);
    pulse_start();
    wait_halt("prog_shl_cma");

    // LDA 3; SHL; SHL; HLT at address 15 -> PC wraps; stray start while busy
    load(4'd12, 8'h43); load(4'd13, 8'h30); load(4'd14, 8'h30); load(4'd15, 8'h70);
    exp_ac(4'd3, 8'h5C); exp_alu(3'b011); exp_ac(4'd0, 8'hB8);
    exp_alu(3'b011); exp_ac(4'd0, 8'h70); exp_halt(16'd20, 4'd0, 8'h70);
    pulse_start();
    repeat (3) @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_halt("prog_wrap");

    // start in HALT resumes at the wrapped PC: LDA 9; HLT
    load(4'd0, 8'h49); load(4'd1, 8'h70);
    exp_ac(4'd9, 8'h4F); exp_halt(16'd10, 4'd2, 8'h4F);
    pulse_start();
    wait_halt("prog_resume");
    check("resume_busy", {39'h0, busy}, 40'h0);

    repeat (3) @(negedge CLK);
    check("sb_drained", 40'(sb_q.size()), 40'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
